key_highlight_drawer: RTL and testbench

Parametrised VGA key-highlight engine for the synth's on-screen keyboard. It draws a BOX_W×BOX_H highlight box on the key for the current note. It tracks which key is highlighted and restores that key's base colour (erase) before highlighting a new one, or on note release. Requests arrive over a req/ready handshake from the synth front end, and pixels stream out to the VGA adapter's plot interface.

---
 rtl/key_highlight_drawer.sv | 144 ++++++++++++++
 tb/tb_key_highlight_drawer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/key_highlight_drawer.sv
// Draws or erases a BOX_W x BOX_H highlight box on an on-screen keyboard key.
// Tracks the highlighted key so it can be restored before a new one is drawn.
module key_highlight_drawer #(
  parameter int          BOX_W        = 4,
  parameter int          BOX_H        = 4,
  parameter logic [2:0]  HI_COLOUR    = 3'b110,
  parameter logic [2:0]  WHITE_COLOUR = 3'b111,
  parameter logic [2:0]  BLACK_COLOUR = 3'b000
) (
  input  logic       iClock,
  input  logic       iResetn,
  input  logic       iReq,
  input  logic [3:0] iNote,
  input  logic       iNoteOn,
  output logic       oReady,
  output logic [8:0] oX,
  output logic [7:0] oY,
  output logic [2:0] oColour,
  output logic       oPlot,
  output logic       oDone
);

  localparam int XW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int YW = (BOX_H > 1) ? $clog2(BOX_H) : 1;

  typedef enum logic [1:0] {IDLE, ERASE, DRAW} state_t;

  state_t          state, state_n;
  logic            hl_valid;
  logic [3:0]      hl_note;
  logic [3:0]      req_note;
  logic            req_on;
  logic [XW-1:0]   xcnt;
  logic [YW-1:0]   ycnt;
  logic [3:0]      key;
  logic [8:0]      kx;
  logic [7:0]      ky;
  logic            kblk;
  logic            busy;
  logic            x_last;
  logic            y_last;
  logic            ph_last;
  logic            start;

  assign oReady  = (state == IDLE);
  assign busy    = (state != IDLE);
  assign x_last  = (xcnt == XW'(BOX_W - 1));
  assign y_last  = (ycnt == YW'(BOX_H - 1));
  assign ph_last = busy && x_last && y_last;
  // Erase always targets the old highlight; draw targets the latched note.
  assign key     = (state == ERASE) ? hl_note : req_note;

  always_comb begin
    {kx, ky, kblk} = '0;
    unique case (key)
      4'd0:    {kx, ky, kblk} = {9'd66,  8'd124, 1'b0};
      4'd1:    {kx, ky, kblk} = {9'd81,  8'd96,  1'b1};
      4'd2:    {kx, ky, kblk} = {9'd99,  8'd124, 1'b0};
      4'd3:    {kx, ky, kblk} = {9'd112, 8'd96,  1'b1};
      4'd4:    {kx, ky, kblk} = {9'd131, 8'd124, 1'b0};
      4'd5:    {kx, ky, kblk} = {9'd161, 8'd124, 1'b0};
      4'd6:    {kx, ky, kblk} = {9'd174, 8'd96,  1'b1};
      4'd7:    {kx, ky, kblk} = {9'd192, 8'd124, 1'b0};
      4'd8:    {kx, ky, kblk} = {9'd209, 8'd96,  1'b1};
      4'd9:    {kx, ky, kblk} = {9'd224, 8'd124, 1'b0};
      4'd10:   {kx, ky, kblk} = {9'd245, 8'd96,  1'b1};
      4'd11:   {kx, ky, kblk} = {9'd254, 8'd124, 1'b0};
      default: {kx, ky, kblk} = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    unique case (state)
      IDLE: begin
        if (iReq) begin
          if (iNoteOn) begin
            if (iNote < 4'd12) begin
              start   = 1'b1;
              state_n = (hl_valid && iNote != hl_note) ? ERASE : DRAW;
            end
          end else if (hl_valid && iNote == hl_note) begin
            start   = 1'b1;
            state_n = ERASE;
          end
        end
      end
      ERASE:   if (ph_last) state_n = req_on ? DRAW : IDLE;
      DRAW:    if (ph_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (!iResetn) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge iClock) begin
    if (!iResetn) begin
      hl_valid <= 1'b0;
      hl_note  <= '0;
      req_note <= '0;
      req_on   <= 1'b0;
      xcnt     <= '0;
      ycnt     <= '0;
      oX       <= '0;
      oY       <= '0;
      oColour  <= '0;
      oPlot    <= 1'b0;
      oDone    <= 1'b0;
    end else begin
      if (start) begin
        req_note <= iNote;
        req_on   <= iNoteOn;
      end
      if (!busy || ph_last) begin
        xcnt <= '0;
        ycnt <= '0;
      end else if (x_last) begin
        xcnt <= '0;
        ycnt <= ycnt + 1'b1;
      end else begin
        xcnt <= xcnt + 1'b1;
      end
      oPlot <= busy;
      // An erase that chains into a draw is not the end of the request.
      oDone <= ph_last && !(state == ERASE && req_on);
      if (busy) begin
        oX      <= kx + 9'(xcnt);
        oY      <= ky + 8'(ycnt);
        oColour <= (state == DRAW) ? HI_COLOUR :
                   (kblk ? BLACK_COLOUR : WHITE_COLOUR);
      end
      if (ph_last && state == DRAW) begin
        hl_valid <= 1'b1;
        hl_note  <= req_note;
      end
      if (ph_last && state == ERASE && !req_on) hl_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_highlight_drawer.sv
// Directed bench for key_highlight_drawer: two instances (4x4 and 8x2 box).
// Each request's pixel stream is captured and set against a hand-built list.
module tb_key_highlight_drawer;

  logic       clk;
  logic       rstn;
  logic       req;
  logic [3:0] note;
  logic       non;
  logic       sel;

  logic       r0, p0, d0, r1, p1, d1;
  logic [8:0] x0, x1;
  logic [7:0] y0, y1;
  logic [2:0] c0, c1;

  logic       ready, plot, done;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] col;

  int ncmp = 0;
  int nerr = 0;
  int bw = 4;
  int bh = 4;
  logic [19:0] expq[$];

  int kx_t[12] = '{66, 81, 99, 112, 131, 161, 174, 192, 209, 224, 245, 254};
  int ky_t[12] = '{124, 96, 124, 96, 124, 124, 96, 124, 96, 124, 96, 124};

  key_highlight_drawer u0 (
    .iClock(clk), .iResetn(rstn), .iReq(req & ~sel), .iNote(note),
    .iNoteOn(non), .oReady(r0), .oX(x0), .oY(y0), .oColour(c0),
    .oPlot(p0), .oDone(d0)
  );

  key_highlight_drawer #(.BOX_W(8), .BOX_H(2)) u1 (
    .iClock(clk), .iResetn(rstn), .iReq(req & sel), .iNote(note),
    .iNoteOn(non), .oReady(r1), .oX(x1), .oY(y1), .oColour(c1),
    .oPlot(p1), .oDone(d1)
  );

  assign ready = sel ? r1 : r0;
  assign plot  = sel ? p1 : p0;
  assign done  = sel ? d1 : d0;
  assign x     = sel ? x1 : x0;
  assign y     = sel ? y1 : y0;
  assign col   = sel ? c1 : c0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_box(input int n, input logic [2:0] c);
    for (int yy = 0; yy < bh; yy++)
      for (int xx = 0; xx < bw; xx++)
        expq.push_back({9'(kx_t[n] + xx), 8'(ky_t[n] + yy), c});
  endtask

  task automatic do_req(input logic [3:0] n, input logic on,
                        input int poke, input int abort);
    int first, last, ndone, done_at, ne;
    logic [19:0] got[$];
    first = -1; last = -1; ndone = 0; done_at = -1;
    ne = expq.size();
    @(negedge clk);
    chk("ready_pre", 32'(ready), 1);
    req = 1'b1; note = n; non = on;
    @(negedge clk);
    req = 1'b0;
    chk("plot_t1", 32'(plot), 0);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (plot) begin
        if (first < 0) first = i;
        last = i;
        got.push_back({x, y, col});
      end
      if (done) begin
        ndone++;
        done_at = i;
        chk("ready_at_done", 32'(ready), 1);
      end
      if (abort >= 0 && i == abort) begin
        chk("abort_pre", got.size(), abort + 1);
        rstn = 1'b0;
        @(negedge clk);
        chk("abort_plot", 32'(plot), 0);
        chk("abort_x", 32'(x), 0);
        rstn = 1'b1;
        expq.delete();
        return;
      end
      if (poke != 0 && i == 3) begin
        req = 1'b1; note = 4'd5; non = 1'b1;
      end
      if (poke != 0 && i == 4) req = 1'b0;
      if (done) break;
      if (ne == 0 && i >= 20) break;
    end
    chk("npix", got.size(), ne);
    if (ne > 0) begin
      chk("first", first, 0);
      chk("contig", last - first + 1, ne);
      chk("done_at", done_at, ne - 1);
      chk("ndone", ndone, 1);
      for (int k = 0; k < ne && k < got.size(); k++)
        chk("pix", 32'(got[k]), 32'(expq[k]));
    end else begin
      chk("ndone_none", ndone, 0);
      chk("ready_idle", 32'(ready), 1);
    end
    expq.delete();
  endtask

  initial begin
    sel = 1'b0; rstn = 1'b0; req = 1'b0; note = '0; non = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_plot", 32'(plot), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_col", 32'(col), 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 1);

    push_box(0, 3'b110);
    do_req(4'd0, 1'b1, 0, -1);

    push_box(0, 3'b111);
    push_box(1, 3'b110);
    do_req(4'd1, 1'b1, 0, -1);

    do_req(4'd3, 1'b0, 0, -1);

    push_box(1, 3'b000);
    do_req(4'd1, 1'b0, 0, -1);

    push_box(2, 3'b110);
    do_req(4'd2, 1'b1, 0, -1);

    do_req(4'd13, 1'b1, 0, -1);

    push_box(2, 3'b110);
    do_req(4'd2, 1'b1, 1, -1);

    push_box(2, 3'b111);
    do_req(4'd4, 1'b1, 0, 4);

    push_box(2, 3'b110);
    do_req(4'd2, 1'b1, 0, -1);

    sel = 1'b1; bw = 8; bh = 2;
    push_box(11, 3'b110);
    do_req(4'd11, 1'b1, 0, -1);
    push_box(11, 3'b110);
    do_req(4'd11, 1'b1, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
